// File: rtl/dpd_coef_bank_pkg.sv
// Shared types and defaults for the DPD coefficient bank.
// The optional readback port is controlled by the DPD_COEF_READBACK_EN macro in the top.
package dpd_coef_bank_pkg;

    localparam int DPD_K_DEF = 3;
    localparam int DPD_M_DEF = 5;
    localparam int DPD_W_DEF = 20;

    typedef logic signed [19:0] s20;

    // Unity gain in Q2.18
    localparam s20 COEF_ONE = 20'sh40000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } coef_bank_state_t;

endpackage

// File: rtl/dpd_coef_ram.sv
// One coefficient bank: N complex words with a single write port and full parallel read.
// Resets to the identity set (coefficient 0 = unity, everything else zero).
module dpd_coef_ram #(
    parameter int N  = 15,
    parameter int W  = 20,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [W-1:0]    wr_re_i,
    input  logic [W-1:0]    wr_im_i,
    output logic [N*W-1:0]  rd_re_o,
    output logic [N*W-1:0]  rd_im_o
);

    localparam logic [N*W-1:0] IDENT_RE = (N*W)'(1) << (W-2);

    logic [N*W-1:0] mem_re_q;
    logic [N*W-1:0] mem_im_q;

    // Storage array; the caller guarantees waddr_i < N whenever we_i is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_re_q <= IDENT_RE;
            mem_im_q <= '0;
        end else if (we_i) begin
            mem_re_q[int'(waddr_i)*W +: W] <= wr_re_i;
            mem_im_q[int'(waddr_i)*W +: W] <= wr_im_i;
        end else begin
            mem_re_q <= mem_re_q;
            mem_im_q <= mem_im_q;
        end
    end

    assign rd_re_o = mem_re_q;
    assign rd_im_o = mem_im_q;

endmodule

// File: rtl/dpd_coef_bank.sv
// Double-buffered K x M complex coefficient bank with sync-aligned swap and copy-back.
// Define DPD_COEF_READBACK_EN to add a registered shadow-bank read port.
module dpd_coef_bank
    import dpd_coef_bank_pkg::*;
#(
    parameter  int K  = DPD_K_DEF,
    parameter  int M  = DPD_M_DEF,
    parameter  int W  = DPD_W_DEF,
    localparam int N  = K*M,
    localparam int AW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [W-1:0]    wr_i,
    input  logic [W-1:0]    wr_q,
    input  logic            commit_req,
    input  logic            sync,
`ifdef DPD_COEF_READBACK_EN
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [W-1:0]    rd_i,
    output logic [W-1:0]    rd_q,
    output logic            rd_valid,
`endif
    output logic [N*W-1:0]  coef_i,
    output logic [N*W-1:0]  coef_q,
    output logic            pending,
    output logic            busy,
    output logic            swap_done,
    output logic            wr_err,
    output logic            cmd_err
);

    localparam logic [N*W-1:0] IDENT_RE = (N*W)'(1) << (W-2);
    localparam logic [AW-1:0]  LAST_IDX = AW'(N-1);

    coef_bank_state_t state_q;
    logic             bank_sel_q;
    logic [AW-1:0]    cnt_q;
    logic             pending_q, busy_q, swapped_q, swap_done_q, wr_err_q, cmd_err_q;
    logic [N*W-1:0]   coef_re_q, coef_im_q;

    logic [N*W-1:0]   b0_re_s, b0_im_s, b1_re_s, b1_im_s;
    logic [N*W-1:0]   act_re_s, act_im_s;
    logic             sw_wr_s, shd_we_s, we0_s, we1_s;
    logic [AW-1:0]    shd_addr_s;
    logic [W-1:0]     shd_re_s, shd_im_s;

    // Bank routing: bank_sel names the active bank, the other one is the shadow
    always_comb begin
        sw_wr_s = wr_en && (int'(wr_addr) < N) && (state_q == IDLE);
        if (bank_sel_q) begin
            act_re_s = b1_re_s;
            act_im_s = b1_im_s;
        end else begin
            act_re_s = b0_re_s;
            act_im_s = b0_im_s;
        end
        if (state_q == COPY) begin
            shd_we_s   = 1'b1;
            shd_addr_s = cnt_q;
            shd_re_s   = act_re_s[int'(cnt_q)*W +: W];
            shd_im_s   = act_im_s[int'(cnt_q)*W +: W];
        end else begin
            shd_we_s   = sw_wr_s;
            shd_addr_s = wr_addr;
            shd_re_s   = wr_i;
            shd_im_s   = wr_q;
        end
        we0_s = shd_we_s && bank_sel_q;
        we1_s = shd_we_s && !bank_sel_q;
    end

    dpd_coef_ram #(.N(N), .W(W), .AW(AW)) u_bank0 (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (we0_s),
        .waddr_i (shd_addr_s),
        .wr_re_i (shd_re_s),
        .wr_im_i (shd_im_s),
        .rd_re_o (b0_re_s),
        .rd_im_o (b0_im_s)
    );

    dpd_coef_ram #(.N(N), .W(W), .AW(AW)) u_bank1 (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (we1_s),
        .waddr_i (shd_addr_s),
        .wr_re_i (shd_re_s),
        .wr_im_i (shd_im_s),
        .rd_re_o (b1_re_s),
        .rd_im_o (b1_im_s)
    );

    // Commit FSM with its status flags and error pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bank_sel_q  <= 1'b0;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            swapped_q   <= 1'b0;
            swap_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            wr_err_q    <= wr_en && !sw_wr_s;
            cmd_err_q   <= commit_req && (state_q != IDLE);
            swapped_q   <= 1'b0;
            swap_done_q <= swapped_q;
            case (state_q)
                IDLE: begin
                    if (commit_req) begin
                        state_q   <= PENDING;
                        pending_q <= 1'b1;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                PENDING: begin
                    if (sync) begin
                        state_q    <= COPY;
                        bank_sel_q <= ~bank_sel_q;
                        cnt_q      <= '0;
                        swapped_q  <= 1'b1;
                        pending_q  <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= PENDING;
                    end
                end
                COPY: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    pending_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Output image of the active bank; all words change on one edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coef_re_q <= IDENT_RE;
            coef_im_q <= '0;
        end else begin
            coef_re_q <= act_re_s;
            coef_im_q <= act_im_s;
        end
    end

    assign coef_i    = coef_re_q;
    assign coef_q    = coef_im_q;
    assign pending   = pending_q;
    assign busy      = busy_q;
    assign swap_done = swap_done_q;
    assign wr_err    = wr_err_q;
    assign cmd_err   = cmd_err_q;

`ifdef DPD_COEF_READBACK_EN
    logic [N*W-1:0] rb_re_s, rb_im_s;
    logic [W-1:0]   rd_re_q, rd_im_q;
    logic           rd_valid_q;

    assign rb_re_s = bank_sel_q ? b0_re_s : b1_re_s;
    assign rb_im_s = bank_sel_q ? b0_im_s : b1_im_s;

    // Shadow readback, one cycle latency, zeros for out-of-range addresses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_re_q    <= '0;
            rd_im_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en && (int'(rd_addr) < N)) begin
                rd_re_q <= rb_re_s[int'(rd_addr)*W +: W];
                rd_im_q <= rb_im_s[int'(rd_addr)*W +: W];
            end else begin
                rd_re_q <= '0;
                rd_im_q <= '0;
            end
        end
    end

    assign rd_i     = rd_re_q;
    assign rd_q     = rd_im_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_dpd_coef_bank.sv
// Directed, table-driven bench for dpd_coef_bank with K=3, M=5, W=20.
module tb_dpd_coef_bank;

    localparam int N  = 15;
    localparam int W  = 20;
    localparam int AW = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [W-1:0]   wr_i = '0;
    logic [W-1:0]   wr_q = '0;
    logic           commit_req = 1'b0;
    logic           sync = 1'b0;
    logic [N*W-1:0] coef_i, coef_q;
    logic           pending, busy, swap_done, wr_err, cmd_err;
    logic [4:0]     flags;
`ifdef DPD_COEF_READBACK_EN
    logic           rd_en = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    logic [W-1:0]   rd_i, rd_q;
    logic           rd_valid;
`endif

    int checks = 0;
    int errors = 0;

    // Expected coefficient sets: 0 identity, 1 A, 2 B, 3 C, 4 identity+[14]
    logic [W-1:0] set_i [5][N];
    logic [W-1:0] set_q [5][N];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  di;
        logic [W-1:0]  dq;
        logic          commit;
        logic          sy;
        logic [4:0]    flags;   // {pending, busy, swap_done, wr_err, cmd_err}
        int            set;
    } vec_t;
    vec_t vt [10];

    assign flags = {pending, busy, swap_done, wr_err, cmd_err};

    always #5 clk = ~clk;

    dpd_coef_bank dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_i       (wr_i),
        .wr_q       (wr_q),
        .commit_req (commit_req),
        .sync       (sync),
`ifdef DPD_COEF_READBACK_EN
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_i       (rd_i),
        .rd_q       (rd_q),
        .rd_valid   (rd_valid),
`endif
        .coef_i     (coef_i),
        .coef_q     (coef_q),
        .pending    (pending),
        .busy       (busy),
        .swap_done  (swap_done),
        .wr_err     (wr_err),
        .cmd_err    (cmd_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pk_i(input int s);
        logic [N*W-1:0] v;
        v = '0;
        for (int n = 0; n < N; n++) v[n*W +: W] = set_i[s][n];
        return v;
    endfunction

    function automatic logic [N*W-1:0] pk_q(input int s);
        logic [N*W-1:0] v;
        v = '0;
        for (int n = 0; n < N; n++) v[n*W +: W] = set_q[s][n];
        return v;
    endfunction

    task automatic chk_set(input string nm, input int s);
        chk({nm, "_coef_i"}, coef_i, pk_i(s));
        chk({nm, "_coef_q"}, coef_q, pk_q(s));
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] a, input logic [W-1:0] di,
                         input logic [W-1:0] dq, input logic cm, input logic sy);
        wr_en = we; wr_addr = a; wr_i = di; wr_q = dq; commit_req = cm; sync = sy;
    endtask

    task automatic wait_idle(input string nm);
        int c;
        c = 0;
        while (busy && c < 40) begin
            step();
            c++;
        end
        chk(nm, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pend_cnt, busy_cnt, sd_cnt;

        for (int n = 0; n < N; n++) begin
            set_i[0][n] = (n == 0) ? 20'h40000 : 20'h00000;
            set_q[0][n] = 20'h00000;
            set_i[1][n] = 20'(n + 1);
            set_q[1][n] = 20'h00000 - 20'(n + 1);
        end
        set_i[2] = set_i[1]; set_q[2] = set_q[1];
        set_i[2][3] = 20'h00ABC; set_q[2][3] = 20'h00DEF;
        set_i[3] = set_i[2]; set_q[3] = set_q[2];
        set_i[3][0] = 20'h7FFFF; set_q[3][0] = 20'h80000;
        set_i[4] = set_i[0]; set_q[4] = set_q[0];
        set_i[4][14] = 20'h00055;

        vt[0] = '{1'b1, 4'd15, 20'h12345, 20'h54321, 1'b0, 1'b0, 5'b00010, 1};
        vt[1] = '{1'b1, 4'd3,  20'h00ABC, 20'h00DEF, 1'b0, 1'b0, 5'b00000, 1};
        vt[2] = '{1'b0, 4'd0,  20'h00000, 20'h00000, 1'b1, 1'b0, 5'b10000, 1};
        vt[3] = '{1'b1, 4'd4,  20'h11111, 20'h22222, 1'b0, 1'b0, 5'b10010, 1};
        vt[4] = '{1'b0, 4'd0,  20'h00000, 20'h00000, 1'b1, 1'b0, 5'b10001, 1};
        vt[5] = '{1'b0, 4'd0,  20'h00000, 20'h00000, 1'b0, 1'b0, 5'b10000, 1};
        vt[6] = '{1'b0, 4'd0,  20'h00000, 20'h00000, 1'b0, 1'b1, 5'b01000, 1};
        vt[7] = '{1'b0, 4'd0,  20'h00000, 20'h00000, 1'b0, 1'b0, 5'b01100, 2};
        vt[8] = '{1'b1, 4'd5,  20'h33333, 20'h44444, 1'b0, 1'b0, 5'b01010, 2};
        vt[9] = '{1'b0, 4'd0,  20'h00000, 20'h00000, 1'b1, 1'b0, 5'b01001, 2};

        // Reset state, both while held and after release
        repeat (2) @(posedge clk);
        #1;
        chk_set("rst_hold", 0);
        chk("rst_hold_flags", flags, 0);
        @(negedge clk) reset_n = 1'b1;
        step();
        chk_set("rst_rel", 0);
        chk("rst_rel_flags", flags, 0);

        // Fill shadow with set A, commit, sync ten cycles later
        for (int n = 0; n < N; n++) begin
            drive(1'b1, AW'(n), set_i[1][n], set_q[1][n], 1'b0, 1'b0);
            step();
            chk("fill_flags", flags, 0);
        end
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("commit_flags", flags, 5'b10000);
        pend_cnt = 1;
        for (int c = 0; c < 9; c++) begin
            step();
            pend_cnt += int'(pending);
        end
        chk("pending_cycles", pend_cnt, 10);
        chk_set("pre_sync", 0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("swap_edge_flags", flags, 5'b01000);
        chk_set("swap_edge", 0);
        step();
        chk("swap_done_flags", flags, 5'b01100);
        chk_set("set_a", 1);
        chk("coef_i7", coef_i[7*W +: W], 20'h00008);
        chk("coef_q7", coef_q[7*W +: W], 20'hFFFF8);
        busy_cnt = 2;
        for (int c = 0; c < 20; c++) begin
            step();
            busy_cnt += int'(busy);
        end
        chk("busy_cycles", busy_cnt, 15);
        chk("post_copy_flags", flags, 0);

        // Error and rejection vectors
        for (int t = 0; t < 10; t++) begin
            drive(vt[t].we, vt[t].addr, vt[t].di, vt[t].dq, vt[t].commit, vt[t].sy);
            step();
            chk($sformatf("vec%0d_flags", t), flags, vt[t].flags);
            chk_set($sformatf("vec%0d", t), vt[t].set);
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        busy_cnt = 0;
        sd_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            busy_cnt += int'(busy);
            sd_cnt += int'(swap_done);
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("vec_busy_tail", busy_cnt, 11);
        chk("no_second_swap", sd_cnt, 0);
        chk_set("no_second_swap", 2);

        // Recommit without writes: the copied-back shadow must equal the active set
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step();
        chk("refill_flags", flags, 5'b01100);
        chk_set("refill", 2);
        wait_idle("refill_idle");

        // Commit and sync in the same cycle must not swap
        drive(1'b1, 4'd0, 20'h7FFFF, 20'h80000, 1'b0, 1'b0);
        step();
        chk("wr_c_flags", flags, 0);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
        step();
        chk("cs_same_flags", flags, 5'b10000);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step();
        chk("cs_wait_flags", flags, 5'b10000);
        chk_set("cs_wait", 2);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("cs_swap_flags", flags, 5'b01000);
        step();
        chk("cs_done_flags", flags, 5'b01100);
        chk_set("set_c", 3);
        wait_idle("set_c_idle");

        // Reset asserted mid-copy with cnt = 6
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        repeat (6) step();
        chk("mid_copy_flags", flags, 5'b01000);
        #2 reset_n = 1'b0;
        #1;
        chk_set("rst_mid", 0);
        chk("rst_mid_flags", flags, 0);
        @(negedge clk) reset_n = 1'b1;
        step();
        chk("rst_mid_rel_flags", flags, 0);
        chk_set("rst_mid_rel", 0);
        drive(1'b1, 4'd14, 20'h00055, 20'h00000, 1'b1, 1'b0);
        step();
        chk("post_rst_commit", flags, 5'b10000);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step();
        chk("post_rst_swap_flags", flags, 5'b01100);
        chk_set("post_rst", 4);
        wait_idle("post_rst_idle");

`ifdef DPD_COEF_READBACK_EN
        rd_en = 1'b1; rd_addr = 4'd14;
        step();
        chk("rd14_valid", rd_valid, 1);
        chk("rd14_i", rd_i, 20'h00055);
        rd_addr = 4'd15;
        step();
        rd_en = 1'b0;
        chk("rd15_valid", rd_valid, 1);
        chk("rd15_i", rd_i, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpd_coef_bank.md
Name: dpd_coef_bank

Overview:
- Parametrised, double-buffered coefficient store for the DPD memory-polynomial datapath. Replaces the fixed 3x5 coefficient interface with a K x M complex bank.
- Software writes a shadow bank one coefficient at a time, then requests a commit.
- The commit swaps shadow and active banks atomically on a datapath sync strobe. The new shadow is then refilled from the active bank, so partial updates are safe.

Parameters:
K, 3, nonlinearity order count (rows)
M, 5, memory depth (taps per row)
W, 20, coefficient width per I/Q component, signed Q2.(W-2)
N (localparam), K*M, total coefficients
AW (localparam), $clog2(N), address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  shadow write strobe
wr_addr  in  AW  coefficient index n = k*M + m
wr_i  in  W  I component to write
wr_q  in  W  Q component to write
commit_req  in  1  single-cycle request to swap banks
sync  in  1  datapath boundary strobe; a swap may occur only here
coef_i  out  N*W  active I coefficients, packed, index n at bits [n*W +: W]
coef_q  out  N*W  active Q coefficients, same packing
pending  out  1  commit armed, waiting for sync
busy  out  1  copy-back in progress
swap_done  out  1  one-cycle pulse: new coefficients present on coef_*
wr_err  out  1  one-cycle pulse: write rejected
cmd_err  out  1  one-cycle pulse: commit rejected

Behaviour:
- Reset (async, reset_n=0):
  - Both banks hold identity: i[0]=2^(W-2), all other i and all q = 0.
  - bank_sel=0, state IDLE, copy counter 0.
  - coef_i/coef_q equal identity. pending=busy=swap_done=wr_err=cmd_err=0.
- FSM states IDLE, PENDING, COPY.
- IDLE:
  - wr_en with wr_addr<N writes shadow[wr_addr] at the edge.
  - commit_req -> PENDING.
  - Write and commit in the same cycle: the write lands first, then PENDING.
  - A sync arriving in the same cycle as commit_req does not swap. The earliest swap is the next sync seen while in PENDING.
- PENDING:
  - pending=1. All writes rejected (wr_err).
  - On a cycle with sync=1: bank_sel toggles at that edge and the state goes to COPY with the counter cleared.
  - coef_* are registered from the active bank. They show the new set one cycle after the swap edge; swap_done pulses in that same cycle.
- COPY:
  - busy=1. Each cycle, shadow[cnt] <= active[cnt] and cnt increments.
  - After cnt = N-1 is written, go to IDLE. COPY lasts exactly N cycles.
  - Writes rejected (wr_err).
- Address checks: wr_en with wr_addr>=N in any state is rejected with a wr_err pulse; neither bank changes.
- Commit checks: commit_req outside IDLE is rejected with a cmd_err pulse; the state is unaffected.
- Error pulses: wr_err and cmd_err are registered and assert one cycle after the offending request.
- Bank isolation: the active bank never changes except via the swap. coef_* are glitch-free and all N coefficients switch in a single edge.
- Reset mid-PENDING or mid-COPY: the whole bank returns to identity and any commit is lost.
- Arithmetic: no arithmetic on data; values are stored verbatim, W bits each. The counter wraps only via the N-1 terminal compare.

Optional Feature:
- Macro DPD_COEF_READBACK_EN.
- Defined:
  - Adds inputs rd_en (1) and rd_addr (AW) from software.
  - Adds outputs rd_i (W), rd_q (W) and rd_valid (1).
  - The shadow word is returned with 1-cycle latency; rd_valid pulses with the data.
  - rd_addr>=N returns zeros with rd_valid=1.
  - A read during COPY returns the shadow content as of that edge.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package additions:
  - typedef s20 for coefficient components.
  - localparams DPD_K_DEF=3, DPD_M_DEF=5.
  - Identity constant COEF_ONE = 20'sh40000.
  - State enum coef_bank_state_t {IDLE, PENDING, COPY}.
- Sub-module dpd_coef_ram: one bank of N x 2W registers with a write port and full parallel read. It is instantiated twice; the top holds the FSM, bank_sel, copy counter and output registers.

Test Plan (K=3, M=5, W=20):
- Reset release -> coef_i[0]=0x40000, all other coefficients 0, all flags 0.
- Write n=0..14 with i=n+1, q=-(n+1); commit; sync 10 cycles later:
  - pending high 10 cycles; swap_done one cycle after the sync edge.
  - coef_i[7]=8, coef_q[7]=0xFFFF8.
  - busy high 15 cycles, then shadow equals active (readback if enabled).
- Write during PENDING, during COPY, and with wr_addr=15 -> wr_err pulse each time; coef_* and shadow unchanged.
- commit_req during PENDING and during COPY -> cmd_err; no second swap on the following sync.
- commit_req and sync in the same cycle -> no swap; the swap occurs at the next sync.
- reset_n low mid-COPY (cnt=6) -> outputs return to identity immediately and the FSM is IDLE after release.
